// File: rtl/seg_pkg.sv
// Shared types and glyph tables for the multiplexed seven-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}; the decimal point is added by the scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: loads on start_i, runs VAL_W shift/add-3 steps, done_o marks the final step.
// Bits carried out of the top BCD digit set a sticky overflow flag for the conversion.
module seg_bin2bcd #(
  parameter int VAL_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      value_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic                  done_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  logic [VAL_W-1:0] sh_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_d;
  logic             carry;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             last;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {adj[BW-2:0], sh_q[VAL_W-1]};
    carry = adj[BW-1];
  end

  assign last = run_q && (cnt_q == CW'(VAL_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= value_i;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_q << 1;
      bcd_q <= bcd_d;
      ovf_q <= ovf_q | carry;
      cnt_q <= cnt_q + CW'(1);
      if (last) run_q <= 1'b0;
    end
  end

  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
  assign done_o = last;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment controller: value handshake, BCD/hex commit, digit scan.
// Decimal commits VAL_W+1 cycles after transfer, hex after 1; the scan never stalls for a conversion.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int VAL_W    = 27,
  parameter int DIV      = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  val_in,
  input  logic              val_valid,
  output logic              val_ready,
  input  logic              hex_mode,
  input  logic [DIGITS-1:0] dp_in,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(DIV);

  state_t           state_q;
  logic [VAL_W-1:0] val_q;
  logic             hex_q;
  logic             rdy_q;
  logic             busy_q;
  logic [BW-1:0]    dig_q;
  logic             ovf_q;

  logic                  xfer;
  logic                  conv_start;
  logic [BW-1:0]         bcd;
  logic                  bcd_ovf;
  logic                  conv_done;
  logic [BW+VAL_W-1:0]   hex_ext;

  assign xfer       = (state_q == ST_IDLE) && val_valid && rdy_q;
  assign conv_start = xfer && !hex_mode;
  assign hex_ext    = {{BW{1'b0}}, val_q};

  seg_bin2bcd #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .value_i (val_in),
    .bcd_o   (bcd),
    .ovf_o   (bcd_ovf),
    .done_o  (conv_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      hex_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            val_q <= val_in;
            hex_q <= hex_mode;
            rdy_q <= 1'b0;
            if (hex_mode) begin
              state_q <= ST_COMMIT;
            end else begin
              state_q <= ST_CONV;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            state_q <= ST_COMMIT;
            busy_q  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          // hex overflow means any value bit above the displayable nibbles
          dig_q   <= hex_q ? hex_ext[BW-1:0] : bcd;
          ovf_q   <= hex_q ? |hex_ext[BW+VAL_W-1:BW] : bcd_ovf;
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign val_ready = rdy_q;
  assign busy      = busy_q;

  logic [DIGITS-1:0][6:0] glyph;
  logic                   lz_nz;

  always_comb begin
    glyph = '0;
    lz_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_nz = lz_nz | (dig_q[4*i +: 4] != 4'd0);
      if (ovf_q) glyph[i] = SEG_DASH;
      else if ((BLANK_LZ != 0) && (i > 0) && !lz_nz) glyph[i] = SEG_BLANK;
      else glyph[i] = nibble_to_seg(dig_q[4*i +: 4]);
    end
  end

  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     act_q;
  logic              lit_q;
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic              tick;
  logic [IW-1:0]     sel;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  assign tick = (presc_q == PW'(DIV - 1));
  assign sel  = tick ? idx_q : act_q;

  // Segments re-render every cycle so commits and dp changes show mid-slot.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = an_q;
    if (tick) an_d = ~(DIGITS'(1) << idx_q);
    if (tick || lit_q) seg_d = {~dp_in[sel], glyph[sel]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      lit_q   <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        act_q <= idx_q;
        lit_q <= 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 8-digit instance against an arithmetic display model every cycle,
// plus a 4-digit no-blanking instance with hand-computed glyph expectations.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [26:0] val_in;
  logic        val_valid;
  logic        val_ready;
  logic        hex_mode;
  logic [7:0]  dp_in;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        busy;

  logic [26:0] v4_val;
  logic        v4_valid;
  logic        v4_ready;
  logic        v4_hex;
  logic [3:0]  v4_dp;
  logic [7:0]  v4_seg;
  logic [3:0]  v4_an;
  logic        v4_busy;

  seg_scan_ctrl #(.DIGITS(8), .VAL_W(27), .DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .val_in(val_in), .val_valid(val_valid), .val_ready(val_ready),
    .hex_mode(hex_mode), .dp_in(dp_in), .seg(seg), .an(an), .busy(busy)
  );

  seg_scan_ctrl #(.DIGITS(4), .VAL_W(27), .DIV(3), .BLANK_LZ(0)) dut4 (
    .clk(clk), .rst(rst), .val_in(v4_val), .val_valid(v4_valid), .val_ready(v4_ready),
    .hex_mode(v4_hex), .dp_in(v4_dp), .seg(v4_seg), .an(v4_an), .busy(v4_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model of the 8-digit instance ----------------
  logic [6:0] gly [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  longint     m_v, p_v;
  bit         m_hex, p_hex, m_rdy, m_busy;
  int         m_e, m_rem, m_k;
  logic [7:0] m_seg, m_an;

  function automatic longint pw(input longint b, input int i);
    longint r = 1;
    for (int k = 0; k < i; k++) r = r * b;
    return r;
  endfunction

  function automatic logic [7:0] m_render(input int i, input logic [7:0] dp);
    longint base = m_hex ? 64'd16 : 64'd10;
    bit     ovf  = (m_v >= pw(base, 8));
    int     d    = int'((m_v / pw(base, i)) % base);
    bit     blk  = (i > 0) && (m_v < pw(base, i));
    logic [6:0] g;
    if (ovf) g = 7'h3F;
    else if (blk) g = 7'h7F;
    else g = gly[d];
    return {~dp[i], g};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0; m_v = 0; m_hex = 0; m_rem = 0; m_rdy = 1; m_busy = 0;
      p_v = 0; p_hex = 0; m_seg = 8'hFF; m_an = 8'hFF;
    end else begin
      m_e++;
      if (m_e >= 4) begin
        m_k   = ((m_e / 4) - 1) % 8;
        m_an  = ~(8'd1 << m_k);
        m_seg = m_render(m_k, dp_in);
      end
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_v = p_v; m_hex = p_hex; m_rdy = 1;
        end
      end else if (val_valid && m_rdy) begin
        p_v = longint'(val_in); p_hex = hex_mode; m_rdy = 0;
        m_rem = hex_mode ? 1 : 28;
      end
      m_busy = (m_rem > 1) && !p_hex;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("seg", seg, m_seg);
      chk("an", an, m_an);
      chk("val_ready", val_ready, m_rdy);
      chk("busy", busy, m_busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [26:0] v, input bit hx);
    int t = 0;
    @(negedge clk);
    while (!val_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("send");
    val_in = v; hex_mode = hx; val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
  endtask

  task automatic see(input string nm, input logic [7:0] a, input logic [7:0] s);
    bit hit = 0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (an == a) begin hit = 1; break; end
    end
    if (hit) chk(nm, seg, s); else timeout(nm);
  endtask

  task automatic send4(input logic [26:0] v, input bit hx);
    int t = 0;
    @(negedge clk);
    while (!v4_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("send4");
    v4_val = v; v4_hex = hx; v4_valid = 1'b1;
    @(negedge clk);
    v4_valid = 1'b0;
  endtask

  task automatic see4(input string nm, input logic [3:0] a, input logic [7:0] s);
    bit hit = 0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (v4_an == a) begin hit = 1; break; end
    end
    if (hit) chk(nm, v4_seg, s); else timeout(nm);
  endtask

  function automatic logic [26:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 27'($urandom_range(0, 999));
      1: return 27'($urandom);
      2: return 27'(99999990 + $urandom_range(0, 19));
      default: return 27'd0;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, nr, len;
    bit hold;
    val_in = '0; val_valid = 0; hex_mode = 0; dp_in = '0;
    v4_val = '0; v4_valid = 0; v4_hex = 0; v4_dp = '0;
    repeat (3) @(negedge clk);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_an", an, 8'hFF);
    chk("reset_ready", val_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_tick_an", an, 8'hFF);
    @(posedge clk);
    #1;
    chk("first_tick_an", an, 8'hFE);
    chk("first_tick_seg", seg, 8'hC0);

    // decimal 12345 and handshake timing
    send(27'd12345, 1'b0);
    nb = 0; nr = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) nb++;
      if (!val_ready) nr++;
      @(negedge clk);
    end
    chk("dec_busy_cycles", nb, 27);
    chk("dec_ready_low_cycles", nr, 28);
    see("dec_d0_5", 8'hFE, 8'h92);
    see("dec_d4_1", 8'hEF, 8'hF9);
    see("dec_d5_blank", 8'hDF, 8'hFF);

    // hex 0xABCD
    send(27'h00ABCD, 1'b1);
    nr = 0;
    for (int c = 0; c < 5; c++) begin
      if (!val_ready) nr++;
      @(negedge clk);
    end
    chk("hex_ready_low_cycles", nr, 1);
    see("hex_d0_D", 8'hFE, 8'hA1);
    see("hex_d3_A", 8'hF7, 8'h88);
    see("hex_d4_blank", 8'hEF, 8'hFF);

    // decimal overflow boundary
    send(27'd100000000, 1'b0);
    repeat (35) @(negedge clk);
    see("ovf_d0_dash", 8'hFE, 8'hBF);
    see("ovf_d7_dash", 8'h7F, 8'hBF);
    dp_in = 8'h04;
    send(27'd99999999, 1'b0);
    repeat (35) @(negedge clk);
    see("max_d7_9", 8'h7F, 8'h90);
    see("max_d2_dp", 8'hFB, 8'h10);
    dp_in = 8'h00;

    // valid held high with alternating values
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      val_valid = 1'b1;
      val_in = (c % 2 == 0) ? 27'd11 : 27'hABC;
      hex_mode = (c % 3 == 0);
    end
    @(negedge clk);
    val_valid = 1'b0;

    // reset mid-conversion discards the value
    send(27'd555, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_ready", val_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_tick_an", an, 8'hFE);
    chk("midrst_tick_seg", seg, 8'hC0);

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      hold = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 60);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        val_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        val_in = rnd_val();
        hex_mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) dp_in = 8'($urandom);
      end
    end
    @(negedge clk);
    val_valid = 1'b0;
    repeat (80) @(negedge clk);

    // 4-digit instance, no leading-zero blanking
    send4(27'h10000, 1'b1);
    repeat (5) @(negedge clk);
    see4("d4_hexovf_d0", 4'hE, 8'hBF);
    see4("d4_hexovf_d3", 4'h7, 8'hBF);
    v4_dp = 4'h4;
    send4(27'd7, 1'b0);
    repeat (32) @(negedge clk);
    see4("d4_seven_d2_dp", 4'hB, 8'h40);
    see4("d4_seven_d0", 4'hE, 8'hF8);
    see4("d4_seven_d3_zero", 4'h7, 8'hC0);
    v4_dp = 4'h0;
    send4(27'd10000, 1'b0);
    repeat (32) @(negedge clk);
    see4("d4_decovf_d0", 4'hE, 8'hBF);
    send4(27'd9999, 1'b0);
    repeat (32) @(negedge clk);
    see4("d4_9999_d3", 4'h7, 8'h90);
    send4(27'h0F00, 1'b1);
    repeat (5) @(negedge clk);
    see4("d4_hexF_d0", 4'hE, 8'hC0);
    see4("d4_hexF_d2", 4'hB, 8'h8E);
    see4("d4_hexF_d3", 4'h7, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
